// File: rtl/player_key_pkg.sv
// Shared types and helpers for the tug-of-war key input stage.
package player_key_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HOLDOFF  = 2'd2
    } key_state_t;

    // Counter width wide enough to hold the larger of the two cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// One key: 2-FF synchroniser, debounce counter, press FSM and optional
// auto-repeat (enabled by KEY_AUTOREPEAT_EN). Emits an unregistered event.
module key_conditioner
    import player_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_game_rst,
    input  logic i_key_n,
    output logic o_event_c
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_acc;       // accepted level, 1 = released
    logic [CW-1:0] r_db_cnt;
    key_state_t    r_state;
    logic          w_press;

    // Two-stage synchroniser for the asynchronous button; idles released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= 1'b1;
            r_db_cnt <= '0;
        end else if (i_game_rst) begin
            r_acc    <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 != r_acc) begin
            if (r_db_cnt == DB_LAST) begin
                r_acc    <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Press tracking; HOLDOFF swallows a key held across a round restart.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RELEASED;
        end else if (i_game_rst) begin
            r_state <= HOLDOFF;
        end else begin
            unique case (r_state)
                RELEASED: if (!r_acc) r_state <= PRESSED;
                PRESSED:  if (r_acc)  r_state <= RELEASED;
                HOLDOFF:  if (r_acc)  r_state <= RELEASED;
                default:              r_state <= RELEASED;
            endcase
        end
    end

    assign w_press = (r_state == RELEASED) && !r_acc;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] r_rep_cnt;
    logic          w_rep_hit;

    assign w_rep_hit = (r_state == PRESSED) && (r_rep_cnt == RP_LAST);

    // Repeat timer runs only while PRESSED, so it is zero on every entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_game_rst) begin
            r_rep_cnt <= '0;
        end else if (r_state == PRESSED) begin
            r_rep_cnt <= w_rep_hit ? '0 : (r_rep_cnt + CW'(1));
        end else begin
            r_rep_cnt <= '0;
        end
    end

    assign o_event_c = w_press | w_rep_hit;
`else
    assign o_event_c = w_press;
`endif

endmodule

// File: rtl/player_key_input.sv
// Tug-of-war key front end: two conditioned keys, same-cycle suppression,
// registered one-cycle L/R pulses. Optional auto-repeat via KEY_AUTOREPEAT_EN.
module player_key_input
    import player_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic gameReset,
    input  logic KeyL_n,
    input  logic KeyR_n,
    output logic L,
    output logic R
);

    logic w_ev_l;
    logic w_ev_r;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_key_l (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_game_rst(gameReset),
        .i_key_n   (KeyL_n),
        .o_event_c (w_ev_l)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_key_r (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_game_rst(gameReset),
        .i_key_n   (KeyR_n),
        .o_event_c (w_ev_r)
    );

    // Register move pulses; simultaneous events cancel each other.
    always_ff @(posedge Clock) begin
        if (Reset || gameReset) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= w_ev_l & ~w_ev_r;
            R <= w_ev_r & ~w_ev_l;
        end
    end

endmodule

// File: tb/tb_player_key_input.sv
// Bench for player_key_input: directed scenarios plus randomized key activity,
// checked by a scoreboard of expected pulses from a reference model.
module tb_player_key_input;

    localparam int DB   = 4;
    localparam int RP   = 10;
    localparam int MAXC = 4000;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic gameReset = 1'b0;
    logic KeyL_n = 1'b1;
    logic KeyR_n = 1'b1;
    logic L;
    logic R;

    player_key_input #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .gameReset(gameReset),
        .KeyL_n   (KeyL_n),
        .KeyR_n   (KeyR_n),
        .L        (L),
        .R        (R)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int cyc;
        bit l;
        bit r;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_n   = 0;
    bit   mon_en   = 1'b0;

    // Reference model: raw samples per key, accepted level, pressed tracking.
    bit raw [2][MAXC];
    bit m_acc [2];      // 1 = released
    int m_since [2];    // edge of last restart of the stability window
    bit m_pv [2];       // a genuine press is being held
    int m_entry [2];    // first edge at which the press is being held
    bit pend [2];       // event in the cycle after the last modelled edge
    int last_rst = -1000;

    // Level seen by the debouncer at edge n: the raw sample two edges earlier.
    function automatic bit dly(input int k, input int n);
        int idx;
        idx = n - 2;
        if (idx < 0 || idx <= last_rst) return 1'b1;
        return raw[k][idx];
    endfunction

    task automatic model_step(input int n, input bit rs, input bit gr);
        bit ev [2];
        bit flip;
        if (!rs && !gr && (pend[0] ^ pend[1]))
            q.push_back('{cyc: n, l: pend[0], r: pend[1]});
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                m_acc[k] = 1'b1; m_since[k] = n; m_pv[k] = 1'b0;
            end else if (gr) begin
                m_acc[k] = 1'b0; m_since[k] = n; m_pv[k] = 1'b0;
            end else begin
                flip = (n - m_since[k]) >= DB;
                for (int j = 0; j < DB; j++)
                    if (dly(k, n - j) == m_acc[k]) flip = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                if (m_pv[k] && n >= m_entry[k] && ((n - m_entry[k]) % RP) == RP - 1)
                    ev[k] = 1'b1;
`endif
                if (flip) begin
                    m_acc[k]   = ~m_acc[k];
                    m_since[k] = n;
                    if (!m_acc[k]) begin
                        ev[k] = 1'b1; m_pv[k] = 1'b1; m_entry[k] = n + 1;
                    end else begin
                        m_pv[k] = 1'b0;
                    end
                end
            end
        end
        if (rs) last_rst = n;
        pend[0] = ev[0];
        pend[1] = ev[1];
    endtask

    task automatic tick(input bit kl, input bit kr, input bit rs, input bit gr);
        int n;
        n = edge_n + 1;
        KeyL_n = kl; KeyR_n = kr; Reset = rs; gameReset = gr;
        raw[0][n] = kl;
        raw[1][n] = kr;
        @(posedge Clock);
        edge_n = n;
        model_step(n, rs, gr);
        #1;
    endtask

    task automatic check_bit(input string name, input bit act, input bit exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0b expected %0b", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every observed pulse must match the next expected pulse.
    always @(negedge Clock) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < edge_n) begin
                n_checks++;
                $display("FAIL missing_pulse: expected L=%0b R=%0b after edge %0d, but no pulse observed",
                         q[0].l, q[0].r, q[0].cyc);
                void'(q.pop_front());
            end
            if (L === 1'b1 || R === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL extra_pulse: got L=%0b R=%0b after edge %0d, expected none",
                             L, R, edge_n);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc != edge_n || e.l !== L || e.r !== R)
                        $display("FAIL pulse: got L=%0b R=%0b at edge %0d, expected L=%0b R=%0b at edge %0d",
                                 L, R, edge_n, e.l, e.r, e.cyc);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        int run_l, run_r;
        bit lv, rv, rs, gr;

        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 1'b1; m_since[k] = 0; m_pv[k] = 1'b0; m_entry[k] = 0; pend[k] = 1'b0;
        end

        // Reset and idle up to edge 9.
        repeat (3) tick(1, 1, 1, 0);
        check_bit("reset_L", L, 1'b0);
        check_bit("reset_R", R, 1'b0);
        mon_en = 1'b1;
        while (edge_n < 9) tick(1, 1, 0, 0);

        // Left press at edge 10 held for 30 cycles.
        repeat (30) tick(0, 1, 0, 0);
        repeat (10) tick(1, 1, 0, 0);
        check_bit("idle_L", L, 1'b0);

        // Right-key glitches shorter than the debounce window.
        repeat (5) begin
            repeat (3) tick(1, 0, 0, 0);
            repeat (2) tick(1, 1, 0, 0);
        end
        repeat (8) tick(1, 1, 0, 0);

        // Both keys pressed together, then right released and re-pressed.
        repeat (15) tick(0, 0, 0, 0);
        repeat (8)  tick(0, 1, 0, 0);
        repeat (12) tick(0, 0, 0, 0);
        repeat (10) tick(1, 1, 0, 0);

        // Left held across a round restart, then released and pressed again.
        repeat (8)  tick(0, 1, 0, 0);
        tick(0, 1, 0, 1);
        repeat (20) tick(0, 1, 0, 0);
        repeat (6)  tick(1, 1, 0, 0);
        repeat (12) tick(0, 1, 0, 0);
        repeat (10) tick(1, 1, 0, 0);

        // Reset two cycles into a right press, key still held afterwards.
        repeat (2)  tick(1, 0, 0, 0);
        repeat (2)  tick(1, 0, 1, 0);
        repeat (15) tick(1, 0, 0, 0);
        repeat (10) tick(1, 1, 0, 0);

        // Long hold exercises auto-repeat when it is built in.
        repeat (40) tick(0, 1, 0, 0);
        repeat (10) tick(1, 1, 0, 0);

        // Randomized key activity with occasional restarts.
        lv = 1'b1; rv = 1'b1; run_l = 0; run_r = 0;
        repeat (1500) begin
            if (run_l == 0) begin
                lv = ~lv; run_l = (lv == 1'b0) ? $urandom_range(1, 25) : $urandom_range(1, 12);
            end
            if (run_r == 0) begin
                rv = ~rv; run_r = (rv == 1'b0) ? $urandom_range(1, 25) : $urandom_range(1, 12);
            end
            run_l--; run_r--;
            rs = ($urandom_range(0, 399) == 0);
            gr = ($urandom_range(0, 199) == 0);
            tick(lv, rv, rs, gr);
        end

        repeat (30) tick(1, 1, 0, 0);
        n_checks++;
        if (q.size() != 0) $display("FAIL leftover: %0d expected pulses never seen, expected 0", q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
